// File: rtl/ham_deser_if.sv
// ham_deser_if: serial input channel plus valid/ready codeword output of the Hamming deserializer
interface ham_deser_if #(
    parameter int CW_W  = 9,
    parameter int CNT_W = 8
);
    logic             ser_in;
    logic             ser_vld;
    logic             frame_start;
    logic [CW_W-1:0]  cw;
    logic             cw_vld;
    logic             cw_rdy;
    logic             frame_err;
    logic             ovf;
    logic             ovf_clr;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output ser_in, ser_vld, frame_start, cw_rdy, ovf_clr,
        input  cw, cw_vld, frame_err, ovf, frame_cnt
    );

    modport slave (
        input  ser_in, ser_vld, frame_start, cw_rdy, ovf_clr,
        output cw, cw_vld, frame_err, ovf, frame_cnt
    );
endinterface

// File: rtl/ham_deser.sv
// ham_deser: collects a framed serial codeword LSB-first and offers it on a valid/ready slot
module ham_deser #(
    parameter int CW_W    = 9,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input logic        clk,
    input logic        rst,
    ham_deser_if.slave bus
);
    localparam int BW = $clog2(CW_W);
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW_W-1:0]  r_shift;
    logic [CW_W-1:0]  w_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [CW_W-1:0]  r_cw;
    logic             r_cw_vld;
    logic             r_frame_err;
    logic             r_ovf;
    logic [CNT_W-1:0] r_frame_cnt;

    logic w_start;
    logic w_bit;
    logic w_done;
    logic w_timeout;
    logic w_load;

    assign w_start   = bus.ser_vld && bus.frame_start;
    assign w_bit     = bus.ser_vld && !bus.frame_start && r_state == RECV;
    assign w_done    = w_bit && r_bit_cnt == BW'(CW_W - 1);
    assign w_timeout = r_state == RECV && !bus.ser_vld && r_gap_cnt == GW'(TIMEOUT - 1);
    assign w_load    = w_done && (!r_cw_vld || bus.cw_rdy);

    // Shift register image including this cycle's bit, so a completing bit lands in cw without delay
    always_comb begin
        w_shift = r_shift;
        if (w_start)
            w_shift[0] = bus.ser_in;
        else if (w_bit)
            w_shift[r_bit_cnt] = bus.ser_in;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: a start bit always (re)enters RECV; completion or timeout returns to IDLE
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_start ? RECV : IDLE)
               : ((w_done || w_timeout) ? IDLE : RECV);
    end

    // Bit assembly, inter-bit gap tracking and abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_shift     <= w_shift;
            r_frame_err <= (r_state == RECV && w_start) || w_timeout;
            if (w_start) begin
                r_bit_cnt <= BW'(1);
                r_gap_cnt <= '0;
            end else if (w_bit) begin
                r_bit_cnt <= w_done ? '0 : r_bit_cnt + BW'(1);
                r_gap_cnt <= '0;
            end else if (r_state == RECV) begin
                r_gap_cnt <= w_timeout ? '0 : r_gap_cnt + GW'(1);
                if (w_timeout)
                    r_bit_cnt <= '0;
            end
        end
    end

    // Output slot: load on completion when free or draining, otherwise flag the drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw        <= '0;
            r_cw_vld    <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_cw_vld <= w_load ? 1'b1 : (r_cw_vld && !bus.cw_rdy);
            r_ovf    <= (w_done && !w_load) ? 1'b1 : (bus.ovf_clr ? 1'b0 : r_ovf);
            if (w_load) begin
                r_cw        <= w_shift;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cw        = r_cw;
    assign bus.cw_vld    = r_cw_vld;
    assign bus.frame_err = r_frame_err;
    assign bus.ovf       = r_ovf;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: doc/ham_deser.md
Name: ham_deser

Overview:
- Serial-to-parallel front end for the 9-bit Hamming (5 info + 4 parity) decoder.
- Collects one framed codeword from a serial channel, position 1 first (cw[0]) through position 9 last (cw[8]).
- Presents the 9-bit word on a valid/ready output that drives the decoder's cw input.
- Detects framing faults (inter-bit timeout, restart mid-frame) and output overflow; counts delivered codewords.

Parameters:
- CW_W, 9, codeword width in bits; bit counter width is $clog2(CW_W).
- TIMEOUT, 16, max idle cycles between bits inside a frame before abort; must be >= 1.
- CNT_W, 8, width of delivered-codeword counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial data bit.
- ser_vld  in  1  ser_in valid this cycle.
- frame_start  in  1  marks the current ser_in as position 1; qualified by ser_vld.
- cw  out  CW_W  assembled codeword; cw[0] = position 1.
- cw_vld  out  1  cw holds an undelivered word.
- cw_rdy  in  1  downstream accepts cw; transfer occurs when cw_vld && cw_rdy.
- frame_err  out  1  one-cycle pulse on frame abort.
- ovf  out  1  sticky: a completed frame was dropped.
- ovf_clr  in  1  clears ovf.
- frame_cnt  out  CNT_W  count of words loaded into cw; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0, cw=0, cw_vld=0, frame_err=0, ovf=0, frame_cnt=0.
- FSM states: IDLE and RECV.
- IDLE:
  - ser_vld && frame_start: shift reg[0] <= ser_in, bit_cnt <= 1, gap_cnt <= 0, go to RECV.
  - ser_vld without frame_start: ignored.
  - frame_start without ser_vld: ignored in every state.
- RECV, ser_vld && !frame_start: shift reg[bit_cnt] <= ser_in, bit_cnt++, gap_cnt <= 0.
- RECV, ser_vld && frame_start (restart): frame_err pulses next cycle; partial word discarded; the bit is taken as position 1 (bit_cnt <= 1); stay in RECV.
- RECV, !ser_vld: gap_cnt++. When gap_cnt reaches TIMEOUT: frame_err pulses, go to IDLE, bit_cnt <= 0.
- Frame completion (bit CW_W-1 sampled):
  - Output slot free (cw_vld==0), or being drained this cycle (cw_vld && cw_rdy): next cycle cw = full word, cw_vld=1, frame_cnt++. Latency is 1 cycle after the last bit.
  - Output slot occupied and not draining: word dropped, ovf <= 1; cw and cw_vld unchanged; frame_cnt unchanged.
  - In both cases go to IDLE.
- The 9-bit assembly uses the completing bit directly, so no extra cycle is lost.
- cw stays stable while cw_vld=1 && cw_rdy=0.
- cw_vld clears after transfer unless a new word loads on the same edge.
- cw is not cleared after transfer; it holds its last value.
- ovf: set has priority over ovf_clr on the same cycle.
- frame_err priority: a restart or timeout pulses exactly once per aborted frame. A timeout and a restart bit can never coincide, because a ser_vld cycle resets gap_cnt.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- The block never inspects parity; error correction belongs to the downstream decoder.

Test Plan:
- Reset, then frame 9'b000001000 sent LSB-first with ser_vld every cycle and cw_rdy=1: cw=9'h008 and cw_vld=1 one cycle after the 9th bit; frame_cnt=1; frame_err=0.
- Two frames back-to-back, 9'b001000111 then 9'b100011001, with cw_rdy=0 throughout:
  - First word held (cw=9'h047).
  - Second frame dropped; ovf=1; frame_cnt=1.
  - ovf_clr pulse then clears ovf.
- Frame 9'b010101010 with 3-cycle ser_vld gaps and TIMEOUT=16: delivered intact, cw=9'h0AA. A gap of 16 cycles after bit 4 gives one frame_err pulse, return to IDLE, no cw_vld.
- frame_start asserted on bit 6 of a frame, then 8 more bits of 9'b000011100: one frame_err pulse; cw=9'h01C delivered.
- cw_rdy asserted on the same cycle a second frame completes: old word transfers, new word 9'h1BA loads with cw_vld held high, no ovf. Then assert rst mid-frame: all outputs return to reset values at once.
- Send 256 frames with CNT_W=8: frame_cnt wraps to 0.
